// File: rtl/axis_frame_arbiter.sv
// Round-robin AXI-Stream video source arbiter that switches sources only on SOF boundaries.
// Define ARB_TIMEOUT_EN to enable the stall watchdog (TIMEOUT_CYCLES); otherwise o_timeout_stb is tied low.
module axis_frame_arbiter #(
    parameter int NUM_INPUTS       = 2,
    parameter int AXIS_DATA_WIDTH  = 8,
    parameter int FRAMES_PER_GRANT = 1,
    parameter int TIMEOUT_CYCLES   = 1024,
    localparam int GID_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                                  i_axi_clk,
    input  logic                                  i_axi_rst,
    input  logic [NUM_INPUTS-1:0]                 i_axis_in_tuser,
    input  logic [NUM_INPUTS-1:0]                 i_axis_in_tvalid,
    output logic [NUM_INPUTS-1:0]                 o_axis_in_tready,
    input  logic [NUM_INPUTS-1:0]                 i_axis_in_tlast,
    input  logic [NUM_INPUTS*AXIS_DATA_WIDTH-1:0] i_axis_in_tdata,
    input  logic [NUM_INPUTS-1:0]                 i_enable_mask,
    output logic                                  o_axis_out_tuser,
    output logic                                  o_axis_out_tvalid,
    input  logic                                  i_axis_out_tready,
    output logic                                  o_axis_out_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]            o_axis_out_tdata,
    output logic                                  o_grant_active,
    output logic [GID_W-1:0]                      o_grant_id,
    output logic                                  o_frame_stb,
    output logic                                  o_timeout_stb
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [GID_W-1:0]        grant_q, grant_d;
    logic [GID_W-1:0]        rr_q, rr_d;
    logic [7:0]              frame_cnt_q, frame_cnt_d;
    logic                    frame_stb_q, frame_stb_d;

    logic [NUM_INPUTS-1:0]   req_s;
    logic [GID_W-1:0]        pick_s;
    logic                    found_s;
    logic                    g_tuser_s;
    logic                    g_tvalid_s;
    logic                    g_tlast_s;
    logic [AXIS_DATA_WIDTH-1:0] g_tdata_s;
    logic                    release_s;
    logic                    accept_s;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    timeout_stb_q, timeout_stb_d;
`else
    logic [31:0]             unused_timeout_s;
    assign unused_timeout_s = TIMEOUT_CYCLES;
`endif

    assign req_s      = i_axis_in_tvalid & i_axis_in_tuser & i_enable_mask;
    assign g_tuser_s  = i_axis_in_tuser[grant_q];
    assign g_tvalid_s = i_axis_in_tvalid[grant_q];
    assign g_tlast_s  = i_axis_in_tlast[grant_q];
    assign g_tdata_s  = i_axis_in_tdata[int'(grant_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];

    // The next SOF on the granted input ends the grant once its quota is used or it was disabled.
    assign release_s = (state_q == ST_STREAM) && g_tvalid_s && g_tuser_s &&
                       ((frame_cnt_q == 8'(FRAMES_PER_GRANT)) || !i_enable_mask[grant_q]);
    assign accept_s  = (state_q == ST_STREAM) && g_tvalid_s && i_axis_out_tready && !release_s;

    // Round-robin search starting just after the last granted input.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            if (!found_s && req_s[(int'(rr_q) + k) % NUM_INPUTS]) begin
                found_s = 1'b1;
                pick_s  = GID_W'((int'(rr_q) + k) % NUM_INPUTS);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Output mux and per-input ready; non-granted inputs drop mid-frame beats and hold their SOF.
    always_comb begin
        o_axis_in_tready  = ~i_axis_in_tuser;
        o_axis_out_tuser  = 1'b0;
        o_axis_out_tvalid = 1'b0;
        o_axis_out_tlast  = 1'b0;
        o_axis_out_tdata  = '0;
        if (i_axi_rst) begin
            o_axis_in_tready = '0;
        end else if (state_q == ST_STREAM) begin
            o_axis_out_tuser          = g_tuser_s;
            o_axis_out_tvalid         = g_tvalid_s && !release_s;
            o_axis_out_tlast          = g_tlast_s;
            o_axis_out_tdata          = g_tdata_s;
            o_axis_in_tready[grant_q] = i_axis_out_tready && !release_s;
        end else begin
            o_axis_in_tready = ~i_axis_in_tuser;
        end
    end

    // Next-state logic for arbitration, frame counting and the optional watchdog.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        frame_cnt_d = frame_cnt_q;
        frame_stb_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wd_d          = '0;
        timeout_stb_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d     = ST_STREAM;
                    grant_d     = pick_s;
                    rr_d        = pick_s;
                    frame_cnt_d = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
`ifdef ARB_TIMEOUT_EN
                wd_d = accept_s ? '0 : (wd_q + WD_W'(1));
`endif
                if (release_s) begin
                    state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (!accept_s && (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d       = ST_IDLE;
                    timeout_stb_d = 1'b1;
`endif
                end else if (accept_s && g_tuser_s) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    frame_stb_d = 1'b1;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and pulse registers with synchronous reset.
    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_q          <= GID_W'(NUM_INPUTS - 1);
            frame_cnt_q   <= 8'd0;
            frame_stb_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_q          <= '0;
            timeout_stb_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_q          <= rr_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_stb_q   <= frame_stb_d;
`ifdef ARB_TIMEOUT_EN
            wd_q          <= wd_d;
            timeout_stb_q <= timeout_stb_d;
`endif
        end
    end

    assign o_grant_active = (state_q == ST_STREAM);
    assign o_grant_id     = grant_q;
    assign o_frame_stb    = frame_stb_q;
`ifdef ARB_TIMEOUT_EN
    assign o_timeout_stb  = timeout_stb_q;
`else
    assign o_timeout_stb  = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter: source beat queues drive the inputs and
// expected output beats are queued at stimulus time and popped on each output transfer.
module tb_axis_frame_arbiter;

    localparam int NI  = 2;
    localparam int DW  = 8;
    localparam int FPG = 1;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NI-1:0]   in_tuser, in_tvalid, in_tready, in_tlast, mask;
    logic [NI*DW-1:0] in_tdata;
    logic            out_tuser, out_tvalid, out_tready, out_tlast;
    logic [DW-1:0]   out_tdata;
    logic            grant_active, frame_stb, timeout_stb;
    logic [0:0]      grant_id;

    typedef struct packed {logic v; logic u; logic l; logic [7:0] d;} beat_t;
    typedef struct packed {logic [0:0] g; logic u; logic l; logic [7:0] d;} exp_t;

    beat_t srcq [NI][$];
    exp_t  expq [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int frame_stb_cnt = 0;
    int timeout_cnt = 0;
    int last_xfer_cyc = -100;
    int out_cnt = 0;
    int in_acc [NI];

    axis_frame_arbiter #(
        .NUM_INPUTS(NI), .AXIS_DATA_WIDTH(DW), .FRAMES_PER_GRANT(FPG), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_axi_clk(clk), .i_axi_rst(rst),
        .i_axis_in_tuser(in_tuser), .i_axis_in_tvalid(in_tvalid), .o_axis_in_tready(in_tready),
        .i_axis_in_tlast(in_tlast), .i_axis_in_tdata(in_tdata), .i_enable_mask(mask),
        .o_axis_out_tuser(out_tuser), .o_axis_out_tvalid(out_tvalid), .i_axis_out_tready(out_tready),
        .o_axis_out_tlast(out_tlast), .o_axis_out_tdata(out_tdata),
        .o_grant_active(grant_active), .o_grant_id(grant_id),
        .o_frame_stb(frame_stb), .o_timeout_stb(timeout_stb)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NI; i++) begin
            if (srcq[i].size() > 0) begin
                in_tvalid[i]         = srcq[i][0].v;
                in_tuser[i]          = srcq[i][0].u;
                in_tlast[i]          = srcq[i][0].l;
                in_tdata[i*DW +: DW] = srcq[i][0].d;
            end else begin
                in_tvalid[i]         = 1'b0;
                in_tuser[i]          = 1'b0;
                in_tlast[i]          = 1'b0;
                in_tdata[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic push_beat(input int src, input logic v, input logic u, input logic l,
                             input logic [7:0] d, input bit ex);
        beat_t b;
        exp_t  e;
        b.v = v; b.u = u; b.l = l; b.d = d;
        srcq[src].push_back(b);
        if (ex) begin
            e.g = src[0]; e.u = u; e.l = l; e.d = d;
            expq.push_back(e);
        end
        drive_inputs();
    endtask

    task automatic push_frame(input int src, input int lines, input int bpl,
                              input logic [7:0] base, input bit ex);
        for (int l = 0; l < lines; l++) begin
            for (int b = 0; b < bpl; b++) begin
                push_beat(src, 1'b1, (l == 0 && b == 0), (b == bpl - 1), base + 8'(l*bpl + b), ex);
            end
        end
    endtask

    // One clock: observe handshakes mid-cycle, then drive the next input values.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (frame_stb)   frame_stb_cnt++;
        if (timeout_stb) timeout_cnt++;
        if (!out_tready && grant_active)
            check_value("bp_ready_low", 32'(in_tready[grant_id]), 32'd0);
        for (int i = 0; i < NI; i++) begin
            if (srcq[i].size() > 0) begin
                if (!srcq[i][0].v) begin
                    void'(srcq[i].pop_front());
                end else if (in_tvalid[i] && in_tready[i]) begin
                    void'(srcq[i].pop_front());
                    in_acc[i]++;
                end
            end
        end
        if (out_tvalid && out_tready) begin
            out_cnt++;
            if (expq.size() == 0) begin
                check_value("out_unexpected", 32'(expq.size()), 32'd1);
            end else begin
                e = expq.pop_front();
                check_value("out_beat", {22'd0, out_tuser, out_tlast, out_tdata}, {22'd0, e.u, e.l, e.d});
                check_value("out_gid", 32'(grant_id), 32'(e.g));
                check_value("out_active", 32'(grant_active), 32'd1);
                if (out_tuser) check_value("sof_gap", 32'(cyc - last_xfer_cyc > 1), 32'd1);
            end
            last_xfer_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
        out_tready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (expq.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check_value(tag, 32'(expq.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            srcq[i].delete();
            in_acc[i] = 0;
        end
        expq.delete();
        mask       = 2'b11;
        in_tvalid  = 2'b11;
        in_tuser   = 2'b00;
        in_tlast   = 2'b00;
        in_tdata   = '0;
        out_tready = 1'b1;
        stall_cnt  = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_value("rst_in_tready", 32'(in_tready), 32'd0);
        check_value("rst_out_tvalid", 32'(out_tvalid), 32'd0);
        check_value("rst_grant_active", 32'(grant_active), 32'd0);
        check_value("rst_grant_id", 32'(grant_id), 32'd0);
        check_value("rst_frame_stb", 32'(frame_stb), 32'd0);
        check_value("rst_timeout_stb", 32'(timeout_stb), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_inputs();
        frame_stb_cnt = 0;
        out_cnt       = 0;
    endtask

    initial begin
        rst = 1'b1;
        mask = 2'b11;
        in_tvalid = '0; in_tuser = '0; in_tlast = '0; in_tdata = '0;
        out_tready = 1'b1;
        for (int i = 0; i < NI; i++) in_acc[i] = 0;

        // Lone source, two frames of 2 lines x 4 beats
        do_reset();
        push_frame(0, 2, 4, 8'h10, 1'b1);
        push_frame(0, 2, 4, 8'h20, 1'b1);
        wait_drain(200, "t1_drain");
        repeat (3) step();
        check_value("t1_frame_stb", 32'(frame_stb_cnt), 32'd2);
        check_value("t1_out_cnt", 32'(out_cnt), 32'd16);

        // Simultaneous SOF: alternation 0,1,0,1; a trailing in0 SOF releases the third grant
        do_reset();
        push_frame(0, 1, 3, 8'h30, 1'b1);
        push_frame(1, 1, 3, 8'h40, 1'b1);
        push_frame(0, 1, 3, 8'h50, 1'b1);
        push_frame(1, 1, 3, 8'h60, 1'b1);
        push_beat(0, 1'b1, 1'b1, 1'b1, 8'h70, 1'b0);
        wait_drain(200, "t2_drain");
        repeat (3) step();
        check_value("t2_frame_stb", 32'(frame_stb_cnt), 32'd4);

        // Mid-frame beats on the non-granted input are flushed
        do_reset();
        push_frame(0, 2, 4, 8'h80, 1'b1);
        for (int k = 0; k < 6; k++) push_beat(1, 1'b1, 1'b0, (k == 5), 8'h90 + 8'(k), 1'b0);
        repeat (6) step();
        check_value("t3_flush_left", 32'(srcq[1].size()), 32'd0);
        check_value("t3_flush_acc", 32'(in_acc[1]), 32'd6);
        wait_drain(200, "t3_drain");

        // Downstream stall of 5 cycles mid-frame
        do_reset();
        push_frame(0, 2, 4, 8'hA0, 1'b1);
        repeat (4) step();
        stall_cnt = 5;
        wait_drain(200, "t4_drain");
        check_value("t4_in_acc", 32'(in_acc[0]), 32'd8);
        check_value("t4_out_cnt", 32'(out_cnt), 32'd8);

        // Disable in0 mid-frame: frame completes, its next SOF stays held, in1 regranted
        do_reset();
        push_frame(0, 2, 4, 8'hB0, 1'b1);
        push_frame(1, 1, 4, 8'hC0, 1'b1);
        push_frame(1, 1, 4, 8'hD0, 1'b1);
        push_frame(0, 1, 4, 8'hE0, 1'b0);
        repeat (3) step();
        mask = 2'b10;
        wait_drain(300, "t5_drain");
        repeat (2) step();
        #1;
        check_value("t5_held_beats", 32'(srcq[0].size()), 32'd4);
        check_value("t5_sof_ready", 32'(in_tready[0]), 32'd0);
        check_value("t5_grant_id", 32'(grant_id), 32'd1);

`ifdef ARB_TIMEOUT_EN
        // in0 stalls 16 cycles mid-frame: watchdog releases, in1 granted
        do_reset();
        push_beat(0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1);
        push_beat(0, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1);
        push_beat(0, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1);
        for (int k = 0; k < 16; k++) push_beat(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) push_beat(0, 1'b1, 1'b0, (k == 4), 8'h04 + 8'(k), 1'b0);
        push_frame(1, 1, 4, 8'hF0, 1'b1);
        wait_drain(300, "t6_drain");
        repeat (2) step();
        check_value("t6_timeout_cnt", 32'(timeout_cnt), 32'd1);
`else
        check_value("no_timeout_stb", 32'(timeout_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
